// File: rtl/jt08_wr_sched.sv
// ----------------------------------------------------------------------------
// jt08_wr_sched -- write scheduler for the YM2608 core bus.
//
// Host register writes {bank, reg, data} are queued in a FIFO and replayed
// as an address strobe followed by a data strobe on opna_cs_n/opna_wr_n/
// opna_addr/opna_din. After each strobe the bus is held idle for the chip's
// post-write wait time, counted in cen ticks. Because of this the host never
// has to poll the chip's busy flag.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   cen               chip clock enable; all strobe and gap timing counts cen ticks
//   flush             discard queued entries (the in-flight write completes)
//   req_valid/ready   host write handshake; req_ready = FIFO not full
//   req_bank/reg/data write entry: bank 0 selects ports 0/1, bank 1 ports 2/3
//   level             FIFO occupancy
//   busy              FIFO non-empty or a write still on the bus
//   opna_cs_n/wr_n    registered strobes to the core (they always move together)
//   opna_addr         registered {bank, phase}; phase 0 = address, 1 = data
//   opna_din          registered register index or register value
// ----------------------------------------------------------------------------
module jt08_wr_sched #(
    parameter int AW       = 4,
    parameter int WR_PULSE = 2,
    parameter int ADDR_GAP = 17,
    parameter int DATA_GAP = 83
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          flush,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_bank,
    input  logic [7:0]    req_reg,
    input  logic [7:0]    req_data,
    output logic [AW:0]   level,
    output logic          busy,
    output logic          opna_cs_n,
    output logic          opna_wr_n,
    output logic [1:0]    opna_addr,
    output logic [7:0]    opna_din
);

    localparam int DEPTH = 1 << AW;
    localparam int MAX_A = (ADDR_GAP > WR_PULSE) ? ADDR_GAP : WR_PULSE;
    localparam int MAX_N = (DATA_GAP > MAX_A) ? DATA_GAP : MAX_A;
    localparam int CW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] PULSE_LD = CW'(WR_PULSE - 1);
    localparam logic [CW-1:0] AGAP_LD  = CW'(ADDR_GAP - 1);
    localparam logic [CW-1:0] DGAP_LD  = CW'(DATA_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_A_STB,
        S_A_GAP,
        S_D_STB,
        S_D_GAP
    } state_t;

    // Entry layout: [16] bank, [15:8] register index, [7:0] register value.
    logic [16:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          empty, full, push, pop;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [16:0]   cur_q, cur_d;

    logic          cs_n_q, cs_n_d;
    logic [1:0]    addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic          busy_q, busy_d;

    assign empty     = (level_q == '0);
    assign full      = (level_q == FULL_LVL);
    assign req_ready = ~full;
    // A push coinciding with flush is discarded. A flush seen in IDLE also
    // holds off the pop, so no new write starts from a queue being cleared.
    assign push      = req_valid & ~full & ~flush;
    assign pop       = (state_q == S_IDLE) & ~empty & ~flush;

    // FIFO pointers and occupancy.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Strobe sequencer: every non-idle state holds for (load+1) cen ticks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        if (state_q != S_IDLE && cen && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_A_STB;
                    cnt_d   = PULSE_LD;
                    cur_d   = mem_q[rd_ptr_q];
                end
            end
            S_A_STB: begin
                if (cen && cnt_q == '0) begin
                    state_d = S_A_GAP;
                    cnt_d   = AGAP_LD;
                end
            end
            S_A_GAP: begin
                if (cen && cnt_q == '0) begin
                    state_d = S_D_STB;
                    cnt_d   = PULSE_LD;
                end
            end
            S_D_STB: begin
                if (cen && cnt_q == '0) begin
                    state_d = S_D_GAP;
                    cnt_d   = DGAP_LD;
                end
            end
            S_D_GAP: begin
                if (cen && cnt_q == '0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Bus outputs follow the current state one clk later; addr/din keep
    // their last value through the gaps and IDLE.
    always_comb begin
        cs_n_d = 1'b1;
        addr_d = addr_q;
        din_d  = din_q;
        case (state_q)
            S_A_STB: begin
                cs_n_d = 1'b0;
                addr_d = {cur_q[16], 1'b0};
                din_d  = cur_q[15:8];
            end
            S_D_STB: begin
                cs_n_d = 1'b0;
                addr_d = {cur_q[16], 1'b1};
                din_d  = cur_q[7:0];
            end
            default: ;
        endcase
        // The extra state_q term keeps busy high until the final strobe
        // edge has actually reached the registered bus outputs.
        busy_d = (level_d != '0) | (state_d != S_IDLE) | (state_q != S_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cur_q    <= '0;
            cs_n_q   <= 1'b1;
            addr_q   <= '0;
            din_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            cs_n_q   <= cs_n_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after a
    // push has written it, so reset muxes on it would buy nothing.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_bank, req_reg, req_data};
    end

    assign level     = level_q;
    assign busy      = busy_q;
    assign opna_cs_n = cs_n_q;
    assign opna_wr_n = cs_n_q;
    assign opna_addr = addr_q;
    assign opna_din  = din_q;

endmodule

// File: tb/tb_jt08_wr_sched.sv
// ----------------------------------------------------------------------------
// tb_jt08_wr_sched -- self-checking bench for jt08_wr_sched.
//
// The reference model treats each write as occupying a fixed number of cen
// ticks (two strobes plus two gaps) after the clk on which it leaves the
// queue. It predicts level/req_ready/busy every clk and pushes the write
// into the expected queue when it leaves the FIFO. A separate monitor
// watches the bus, reassembles {bank, reg, data} from each strobe pair and
// checks it against that queue, together with the strobe and gap lengths.
// ----------------------------------------------------------------------------
module tb_jt08_wr_sched;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int WP    = 2;
    localparam int AG    = 17;
    localparam int DG    = 83;
    localparam int TOTAL = 2 * WP + AG + DG;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_bank = 1'b0;
    logic [7:0]  req_reg = '0;
    logic [7:0]  req_data = '0;
    logic        req_ready, busy, opna_cs_n, opna_wr_n;
    logic [AW:0] level;
    logic [1:0]  opna_addr;
    logic [7:0]  opna_din;

    jt08_wr_sched #(.AW(AW), .WR_PULSE(WP), .ADDR_GAP(AG), .DATA_GAP(DG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_bank  (req_bank),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .level     (level),
        .busy      (busy),
        .opna_cs_n (opna_cs_n),
        .opna_wr_n (opna_wr_n),
        .opna_addr (opna_addr),
        .opna_din  (opna_din)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int min);
        total++;
        if (act < min) begin
            bad++;
            $display("FAIL %s: got %0d expected at least %0d at %0t", name, act, min, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [16:0] mq[$];      // entries waiting in the FIFO
    logic [16:0] exp_q[$];   // entries that have left the FIFO, in bus order
    int          rem = 0;    // cen ticks left for the write in flight
    bit          m_busy = 1'b0;
    int          cen_mode = 0;   // 0: always, 1: every 3rd clk, 2: random
    int          cph = 0;

    function automatic bit gen_cen();
        bit r;
        case (cen_mode)
            0:       r = 1'b1;
            1:       r = (cph % 3 == 0);
            default: r = ($urandom_range(0, 1) == 1);
        endcase
        cph++;
        return r;
    endfunction

    // Called on a negedge: check the state produced by the last posedge,
    // drive inputs for the next one and advance the model across it.
    task automatic step(input bit v, input logic [16:0] e, input bit fl, output bit acc);
        bit c;
        int rem_before;
        check("level", 32'(level), 32'(mq.size()));
        check("req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
        check("busy", 32'(busy), 32'(m_busy));
        c = gen_cen();
        req_valid = v;
        {req_bank, req_reg, req_data} = e;
        flush = fl;
        cen = c;
        acc = v && (mq.size() < DEPTH) && !fl;
        rem_before = rem;
        if (rem == 0 && mq.size() > 0 && !fl) begin
            exp_q.push_back(mq.pop_front());
            rem = TOTAL;
        end else if (rem > 0 && c) begin
            rem--;
        end
        if (fl) mq.delete();
        else if (acc) mq.push_back(e);
        m_busy = (mq.size() > 0) || (rem > 0) || (rem_before > 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_step();
        bit acc;
        step(1'b0, '0, 1'b0, acc);
    endtask

    task automatic send(input logic [16:0] e);
        bit acc;
        int n = 0;
        do begin
            step(1'b1, e, 1'b0, acc);
            n++;
        end while (!acc && n < 1000);
        if (!acc) check("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic drain();
        int n = 0;
        while ((mq.size() > 0 || rem > 0 || m_busy) && n < 20000) begin
            idle_step();
            n++;
        end
        if (n >= 20000) check("drain_timeout", 32'(0), 32'(1));
        idle_step();
        idle_step();
    endtask

    // ---------------- bus monitor / scoreboard ----------------
    bit          mon_en = 1'b0;
    bit          exact = 1'b0;
    int          exp_pulse = WP, exp_agap = AG, exp_bfall = DG;
    int          cyc = 0, lo_cnt = 0, hi_cnt = 0, d_end = 0;
    bit          cs_prev = 1'b1, busy_prev = 1'b0, have_a = 1'b0, seen_d = 1'b0;
    logic [1:0]  s_addr, a_addr;
    logic [7:0]  s_din, a_din;
    logic [16:0] e;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            check("wr_n_follows_cs_n", 32'(opna_wr_n), 32'(opna_cs_n));
            if (!opna_cs_n) begin
                if (cs_prev) begin
                    if (opna_addr[0]) begin
                        check("pairing_data", 32'(have_a), 32'(1));
                        if (exact) check("addr_gap", 32'(hi_cnt), 32'(exp_agap));
                        else       check_ge("addr_gap_min", hi_cnt, AG);
                    end else begin
                        check("pairing_addr", 32'(have_a), 32'(0));
                        if (seen_d) check_ge("data_gap_min", hi_cnt, DG);
                    end
                    s_addr = opna_addr;
                    s_din  = opna_din;
                    lo_cnt = 0;
                end else begin
                    check("addr_stable", 32'(opna_addr), 32'(s_addr));
                    check("din_stable", 32'(opna_din), 32'(s_din));
                end
                lo_cnt++;
            end else begin
                if (!cs_prev) begin
                    if (exact) check("pulse", 32'(lo_cnt), 32'(exp_pulse));
                    else       check_ge("pulse_min", lo_cnt, WP);
                    if (s_addr[0]) begin
                        check("write_expected", 32'(exp_q.size() != 0), 32'(1));
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("addr_bank", 32'(a_addr[1]), 32'(e[16]));
                            check("data_bank", 32'(s_addr[1]), 32'(e[16]));
                            check("reg", 32'(a_din), 32'(e[15:8]));
                            check("data", 32'(s_din), 32'(e[7:0]));
                        end
                        have_a = 1'b0;
                        seen_d = 1'b1;
                        d_end  = cyc;
                    end else begin
                        a_addr = s_addr;
                        a_din  = s_din;
                        have_a = 1'b1;
                    end
                    hi_cnt = 0;
                end
                hi_cnt++;
            end
            if (busy_prev && !busy && exact) check("busy_fall", 32'(cyc - d_end), 32'(exp_bfall));
            cs_prev   = opna_cs_n;
            busy_prev = busy;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          acc, pend;
        logic [16:0] pe;
        int          n;

        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(opna_cs_n), 32'(1));
        check("rst_wr_n", 32'(opna_wr_n), 32'(1));
        check("rst_addr", 32'(opna_addr), 32'(0));
        check("rst_din", 32'(opna_din), 32'(0));
        check("rst_level", 32'(level), 32'(0));
        check("rst_ready", 32'(req_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Single bank-0 write, cen always high: exact bus timing.
        cen_mode = 0; exact = 1'b1;
        exp_pulse = WP; exp_agap = AG; exp_bfall = DG;
        send({1'b0, 8'h28, 8'hF1});
        drain();

        // Bank-1 write with cen every 3rd clk; the pop lands on a cen clk.
        cen_mode = 1;
        exp_pulse = 3 * WP; exp_agap = 3 * AG; exp_bfall = 3 * DG;
        while (cph % 3 != 2) idle_step();
        send({1'b1, 8'hA4, 8'h3C});
        drain();

        // Back-to-back fill: the 18th request waits for a pop.
        cen_mode = 0; exp_pulse = WP; exp_agap = AG; exp_bfall = DG;
        for (int i = 0; i < 18; i++) send(17'($urandom));
        drain();

        // Flush while the in-flight write is in its data strobe.
        for (int i = 0; i < 6; i++) send(17'($urandom));
        n = 0;
        while (rem != DG + 1 && n < 1000) begin
            idle_step();
            n++;
        end
        check("flush_queue_depth", 32'(mq.size()), 32'(5));
        check("flush_in_dstb", 32'(opna_cs_n), 32'(0));
        step(1'b1, 17'h1_5555, 1'b1, acc);
        check("flush_level", 32'(level), 32'(0));
        drain();

        // Push and pop on the same clk with one entry queued.
        send(17'h0_1122);
        send(17'h1_3344);
        n = 0;
        while (!(rem == 0 && mq.size() == 1) && n < 1000) begin
            idle_step();
            n++;
        end
        step(1'b1, 17'h0_5566, 1'b0, acc);
        check("pushpop_accept", 32'(acc), 32'(1));
        check("pushpop_level", 32'(level), 32'(1));
        drain();

        // Randomised traffic with random cen and occasional flush.
        cen_mode = 2; exact = 1'b0;
        pend = 1'b0; pe = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend = 1'b1;
                pe = 17'($urandom);
            end
            step(pend, pe, $urandom_range(0, 399) == 0, acc);
            if (acc) pend = 1'b0;
        end
        drain();
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        // Asynchronous reset in the middle of an address strobe.
        mon_en = 1'b0;
        cen_mode = 0;
        send(17'h1_77EE);
        n = 0;
        while (opna_cs_n && n < 10) begin
            idle_step();
            n++;
        end
        check("pre_reset_strobe", 32'(opna_cs_n), 32'(0));
        #1 rst_n = 1'b0;
        #1;
        check("async_cs_n", 32'(opna_cs_n), 32'(1));
        check("async_wr_n", 32'(opna_wr_n), 32'(1));
        check("async_addr", 32'(opna_addr), 32'(0));
        check("async_level", 32'(level), 32'(0));
        check("async_ready", 32'(req_ready), 32'(1));
        check("async_busy", 32'(busy), 32'(0));
        #1 rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
